// File: rtl/render_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | render_pkg : geometry/colour defaults and raster FSM states shared |
// | by the 2D render blocks.                            rev 1.0        |
// +--------------------------------------------------------------------+
package render_pkg;

  localparam int DEF_X_W      = 9;
  localparam int DEF_Y_W      = 8;
  localparam int DEF_COLOR_W  = 3;
  localparam int DEF_THICK_W  = 3;
  localparam int DEF_SCREEN_W = 320;
  localparam int DEF_SCREEN_H = 240;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2,
    ST_DONE  = 2'd3
  } raster_state_e;

endpackage
`default_nettype wire

// File: rtl/rect_raster_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rect_raster_if : valid/ready pixel stream (x, y, colour).          |
// |                                                     rev 1.0        |
// +--------------------------------------------------------------------+
interface rect_raster_if
  import render_pkg::*;
#(
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int COLOR_W = DEF_COLOR_W
);
  logic               pix_valid;
  logic               pix_ready;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [COLOR_W-1:0] pix_color;

  modport master (output pix_valid, pix_x, pix_y, pix_color, input pix_ready);
  modport slave  (input pix_valid, pix_x, pix_y, pix_color, output pix_ready);
endinterface
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | raster_counter : cx/cy raster walker with load, advance and last.  |
// |                                                     rev 1.0        |
// +--------------------------------------------------------------------+
module raster_counter
  import render_pkg::*;
#(
  parameter int X_W = DEF_X_W,
  parameter int Y_W = DEF_Y_W
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load,
  input  logic           advance,
  input  logic [X_W-1:0] start_x,
  input  logic [Y_W-1:0] start_y,
  input  logic [X_W:0]   x_end,
  input  logic [Y_W:0]   y_end,
  output logic [X_W-1:0] cx,
  output logic [Y_W-1:0] cy,
  output logic [X_W-1:0] nx,
  output logic [Y_W-1:0] ny,
  output logic           last
);
  localparam logic [X_W:0] X_ONE = (X_W+1)'(1);
  localparam logic [Y_W:0] Y_ONE = (Y_W+1)'(1);

  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           row_end;

  // x_end/y_end are exclusive bounds, so the final column/row is end-1
  assign row_end = ({1'b0, cx_q} == (x_end - X_ONE));
  assign last    = row_end && ({1'b0, cy_q} == (y_end - Y_ONE));

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load) begin
      cx_d = start_x;
      cy_d = start_y;
    end else if (advance) begin
      if (row_end) begin
        cx_d = start_x;
        cy_d = cy_q + Y_W'(1);
      end else begin
        cx_d = cx_q + X_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx = cx_q;
  assign cy = cy_q;
  assign nx = cx_d;
  assign ny = cy_d;
endmodule
`default_nettype wire

// File: rtl/rect_raster.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rect_raster : clipped raster-order rectangle walker with optional  |
// | border (RECT_BORDER_EN).                            rev 1.0        |
// +--------------------------------------------------------------------+
module rect_raster
  import render_pkg::*;
#(
  parameter int X_W      = DEF_X_W,
  parameter int Y_W      = DEF_Y_W,
  parameter int COLOR_W  = DEF_COLOR_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int THICK_W  = DEF_THICK_W
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [X_W-1:0]     origin_x,
  input  logic [Y_W-1:0]     origin_y,
  input  logic [X_W-1:0]     width,
  input  logic [Y_W-1:0]     height,
  input  logic [COLOR_W-1:0] back_color,
  input  logic [COLOR_W-1:0] border_color,
  input  logic [THICK_W-1:0] border_thick,
  output logic               busy,
  output logic               done,
  rect_raster_if.master      pix
);
  localparam logic [X_W:0] X_SCR = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] Y_SCR = (Y_W+1)'(SCREEN_H);

  raster_state_e      state_q, state_d;
  logic [X_W-1:0]     ox_q, ox_d, w_q, w_d;
  logic [Y_W-1:0]     oy_q, oy_d, h_q, h_d;
  logic [COLOR_W-1:0] back_q, back_d, border_q, border_d, color_q, color_d;
  logic [THICK_W-1:0] thick_q, thick_d;
  logic [X_W:0]       x_end_q, x_end_d, sum_x, x_end_calc;
  logic [Y_W:0]       y_end_q, y_end_d, sum_y, y_end_calc;
  logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
  logic               empty, load, advance, last, pick_border;
  logic [X_W-1:0]     cx, nx;
  logic [Y_W-1:0]     cy, ny;

  raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_counter (
    .clk     (clk),
    .resetn  (resetn),
    .load    (load),
    .advance (advance),
    .start_x (ox_q),
    .start_y (oy_q),
    .x_end   (x_end_q),
    .y_end   (y_end_q),
    .cx      (cx),
    .cy      (cy),
    .nx      (nx),
    .ny      (ny),
    .last    (last)
  );

  // One extra bit keeps origin+size from wrapping before the screen clip
  always_comb begin
    sum_x      = {1'b0, ox_q} + {1'b0, w_q};
    sum_y      = {1'b0, oy_q} + {1'b0, h_q};
    x_end_calc = (sum_x > X_SCR) ? X_SCR : sum_x;
    y_end_calc = (sum_y > Y_SCR) ? Y_SCR : sum_y;
    empty      = (w_q == '0) || (h_q == '0) ||
                 ({1'b0, ox_q} >= X_SCR) || ({1'b0, oy_q} >= Y_SCR);
  end

  always_comb begin
    state_d  = state_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    w_d      = w_q;
    h_d      = h_q;
    back_d   = back_q;
    border_d = border_q;
    thick_d  = thick_q;
    x_end_d  = x_end_q;
    y_end_d  = y_end_q;
    load     = 1'b0;
    advance  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        ox_d     = origin_x;
        oy_d     = origin_y;
        w_d      = width;
        h_d      = height;
        back_d   = back_color;
        border_d = border_color;
        thick_d  = border_thick;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        x_end_d = x_end_calc;
        y_end_d = y_end_calc;
        if (empty) begin
          state_d = ST_DONE;
        end else begin
          load    = 1'b1;
          state_d = ST_DRAW;
        end
      end
      ST_DRAW: if (pix.pix_ready) begin
        advance = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      load    = 1'b0;
      advance = 1'b0;
    end
  end

  assign busy_d  = (state_d != ST_IDLE);
  assign done_d  = (state_d == ST_DONE);
  assign valid_d = (state_d == ST_DRAW);

`ifdef RECT_BORDER_EN
  logic [X_W-1:0] col;
  logic [Y_W-1:0] row;

  // Border test uses the unclipped rectangle so clipping never moves the edge
  function automatic logic in_border(input logic [X_W-1:0] c, input logic [Y_W-1:0] r,
                                     input logic [X_W-1:0] w, input logic [Y_W-1:0] h,
                                     input logic [THICK_W-1:0] t);
    logic [X_W-1:0] tx;
    logic [Y_W-1:0] ty;
    tx = X_W'(t);
    ty = Y_W'(t);
    if (t == '0) return 1'b0;
    if ((tx >= w) || (ty >= h)) return 1'b1;
    return (c < tx) || (c >= w - tx) || (r < ty) || (r >= h - ty);
  endfunction

  always_comb begin
    col         = nx - ox_q;
    row         = ny - oy_q;
    pick_border = in_border(col, row, w_q, h_q, thick_q);
  end
`else
  logic unused_border;
  assign pick_border   = 1'b0;
  assign unused_border = ^{thick_q, nx, ny};
`endif

  assign color_d = (load || advance) ? (pick_border ? border_q : back_q) : color_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      ox_q     <= '0;
      oy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      back_q   <= '0;
      border_q <= '0;
      thick_q  <= '0;
      x_end_q  <= '0;
      y_end_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      color_q  <= '0;
    end else begin
      state_q  <= state_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      w_q      <= w_d;
      h_q      <= h_d;
      back_q   <= back_d;
      border_q <= border_d;
      thick_q  <= thick_d;
      x_end_q  <= x_end_d;
      y_end_q  <= y_end_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      color_q  <= color_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign pix.pix_valid = valid_q;
  assign pix.pix_x     = cx;
  assign pix.pix_y     = cy;
  assign pix.pix_color = color_q;
endmodule
`default_nettype wire

// File: tb/tb_rect_raster.sv
`default_nettype none
// Directed scoreboard bench for rect_raster; expected pixels are queued from a
// reference model and popped by a monitor on every accepted handshake.
module tb_rect_raster;
  import render_pkg::*;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [8:0] origin_x = '0;
  logic [7:0] origin_y = '0;
  logic [8:0] width = '0;
  logic [7:0] height = '0;
  logic [2:0] back_color = '0;
  logic [2:0] border_color = '0;
  logic [2:0] border_thick = '0;
  logic       busy, done;

  pix_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   accepted = 0;
  logic held_v = 1'b0;
  pix_t held = '0;
  int   base, n;

  rect_raster_if #(.X_W(9), .Y_W(8), .COLOR_W(3)) pif ();

  rect_raster dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .abort        (abort),
    .origin_x     (origin_x),
    .origin_y     (origin_y),
    .width        (width),
    .height       (height),
    .back_color   (back_color),
    .border_color (border_color),
    .border_thick (border_thick),
    .busy         (busy),
    .done         (done),
    .pix          (pif.master)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model_color(input int col, input int row, input int w,
                                             input int h, input int t,
                                             input logic [2:0] back, input logic [2:0] border);
    logic is_b;
    is_b = (t > 0) && ((t >= w) || (t >= h) || (col < t) || (col >= w - t) ||
                       (row < t) || (row >= h - t));
`ifndef RECT_BORDER_EN
    is_b = 1'b0;
`endif
    return is_b ? border : back;
  endfunction

  task automatic push_rect(input int ox, input int oy, input int w, input int h,
                           input logic [2:0] back, input logic [2:0] border, input int t,
                           output int cnt);
    pix_t p;
    cnt = 0;
    for (int y = oy; y < oy + h && y < 240; y++) begin
      for (int x = ox; x < ox + w && x < 320; x++) begin
        p.x = 9'(x);
        p.y = 8'(y);
        p.c = model_color(x - ox, y - oy, w, h, t, back, border);
        sb.push_back(p);
        cnt++;
      end
    end
  endtask

  // Monitor: a pixel is consumed when valid&&ready and no abort in that cycle
  always @(negedge clk) begin
    if (pif.pix_valid) begin
      if (held_v) check("stall_hold", {pif.pix_x, pif.pix_y, pif.pix_color}, held);
      if (pif.pix_ready && !abort) begin
        accepted <= accepted + 1;
        held_v   <= 1'b0;
        if (sb.size() == 0) check("extra_pixel", sb.size(), 1);
        else check("pixel", {pif.pix_x, pif.pix_y, pif.pix_color}, sb.pop_front());
      end else begin
        held_v <= 1'b1;
        held   <= {pif.pix_x, pif.pix_y, pif.pix_color};
      end
    end else begin
      held_v <= 1'b0;
    end
  end

  task automatic run_rect(input string tag, input int ox, input int oy, input int w,
                          input int h, input logic [2:0] back, input logic [2:0] border,
                          input int t, input bit stall);
    int cnt, k, acc0;
    bit got;
    logic [3:0] pat;
    pat = 4'b1001;
    push_rect(ox, oy, w, h, back, border, t, cnt);
    @(posedge clk); #1;
    acc0         = accepted;
    origin_x     = 9'(ox);
    origin_y     = 8'(oy);
    width        = 9'(w);
    height       = 8'(h);
    back_color   = back;
    border_color = border;
    border_thick = 3'(t);
    start        = 1'b1;
    pif.pix_ready = 1'b1;
    got = 1'b0;
    k   = 0;
    while (!got && k < 400) begin
      @(posedge clk); #1;
      k++;
      start        = 1'b0;
      origin_x     = 9'($urandom);
      origin_y     = 8'($urandom);
      width        = 9'($urandom);
      height       = 8'($urandom);
      back_color   = 3'($urandom);
      border_color = 3'($urandom);
      border_thick = 3'($urandom);
      pif.pix_ready = stall ? pat[k % 4] : 1'b1;
      if (done) got = 1'b1;
    end
    check({tag, " done_seen"}, 32'(got), 1);
    if (!stall) check({tag, " done_cycle"}, k, cnt + 2);
    check({tag, " busy_at_done"}, 32'(busy), 1);
    check({tag, " accepted"}, accepted - acc0, cnt);
    check({tag, " sb_empty"}, sb.size(), 0);
    @(posedge clk); #1;
    check({tag, " idle_busy"}, 32'(busy), 0);
    check({tag, " idle_done"}, 32'(done), 0);
    pif.pix_ready = 1'b1;
    sb.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    pif.pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_valid", 32'(pif.pix_valid), 0);
    check("rst_x", 32'(pif.pix_x), 0);
    check("rst_y", 32'(pif.pix_y), 0);
    check("rst_color", 32'(pif.pix_color), 0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_rect("basic4x3", 10, 20, 4, 3, 3'b010, 3'b000, 0, 1'b0);
    run_rect("border5x5", 0, 0, 5, 5, 3'b001, 3'b111, 1, 1'b0);
    run_rect("clip", 318, 238, 4, 4, 3'b110, 3'b000, 0, 1'b0);
    run_rect("empty_w0", 30, 30, 0, 5, 3'b011, 3'b000, 0, 1'b0);
    run_rect("empty_off", 320, 10, 4, 4, 3'b011, 3'b000, 0, 1'b0);
    run_rect("thick_ge_w", 200, 100, 2, 2, 3'b011, 3'b100, 3, 1'b0);
    run_rect("stall3x2", 40, 50, 3, 2, 3'b101, 3'b000, 0, 1'b1);
    run_rect("border_stall", 7, 9, 6, 4, 3'b010, 3'b110, 2, 1'b1);

    // Abort after two accepted pixels of a 4x2 rectangle
    push_rect(50, 60, 2, 1, 3'b101, 3'b000, 0, n);
    @(posedge clk); #1;
    base = accepted;
    origin_x = 9'd50; origin_y = 8'd60; width = 9'd4; height = 8'd2;
    back_color = 3'b101; border_thick = 3'd0; start = 1'b1; pif.pix_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_valid", 32'(pif.pix_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("abort_no_done", 32'(done), 0);
    end
    check("abort_accepted", accepted - base, 2);
    check("abort_sb_empty", sb.size(), 0);
    sb.delete();
    run_rect("after_abort", 12, 3, 3, 3, 3'b100, 3'b000, 0, 1'b0);

    // Asynchronous reset in the middle of DRAW
    push_rect(100, 100, 8, 4, 3'b011, 3'b000, 0, n);
    @(posedge clk); #1;
    origin_x = 9'd100; origin_y = 8'd100; width = 9'd8; height = 8'd4;
    back_color = 3'b011; border_thick = 3'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    check("mid_rst_valid", 32'(pif.pix_valid), 0);
    check("mid_rst_x", 32'(pif.pix_x), 0);
    check("mid_rst_y", 32'(pif.pix_y), 0);
    check("mid_rst_color", 32'(pif.pix_color), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    run_rect("after_reset", 0, 0, 5, 5, 3'b001, 3'b111, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
